sip_dot_slice_sched: RTL and testbench
======================================

// Module: sip_dot_slice_sched
// PURPOSE
// Sequences one bit-sliced dot-product job through the sip_dot / sip_dot_adder datapath.
// Walks every (weight slice, activation slice) pair across NUM_TILES reduction tiles.
// Drives slice/tile indices and the SignI/SignW flags to operand fetch and the MUL array.
// Shift-accumulates returned adder sums into one signed result, delivered on a valid/ready port.
// PARAMETERS
// SLICE_W    2   bits per slice (BITS_PARALLEL); shift step per slice position
// MAX_SLC    4   max slices per operand; precision fields encode 1..MAX_SLC
// PSUM_W     11  width of sip_dot_adder output (BITS_SIP_DOT_ADDER)
// ACC_W      32  accumulator/result width, signed
// TILE_W     8   width of tile count/index
// PSUM_LAT   1   cycles from o_Issue to matching i_Psum (>=1)
// PORTS
// i_CLK      in   1        clock
// i_RST      in   1        synchronous reset, active high
// i_JobValid in   1        job request
// o_JobReady out  1        high only in IDLE
// i_PrecA    in   2        activation slices minus 1 (0->1 slice .. 3->4 slices)
// i_PrecW    in   2        weight slices minus 1
// i_NumTiles in   TILE_W   reduction tiles minus 1
// o_Issue    out  1        one slice pair presented to datapath this cycle
// o_TileIdx  out  TILE_W   tile index of issued pair
// o_ASlice   out  2        activation slice index (0 = LSB slice)
// o_WSlice   out  2        weight slice index
// o_SignI    out  1        issued activation slice is MSB slice (signed)
// o_SignW    out  1        issued weight slice is MSB slice (signed)
// i_Psum     in   PSUM_W   signed sip_dot_adder sum, valid PSUM_LAT cycles after o_Issue
// o_ResValid out  1        result available
// i_ResReady in   1        result consumer ready
// o_Result   out  ACC_W    signed accumulated dot product
// o_Busy     out  1        state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; o_JobReady=1; o_Issue, o_ResValid, o_Busy = 0; o_Result, indices, signs = 0;
//   issue-delay line cleared, so in-flight psums are discarded. Reset mid-job aborts it.
// - Handshake: job accepted on i_JobValid & o_JobReady; PrecA/PrecW/NumTiles latched; accumulator cleared.
// - States: IDLE -> ISSUE (job accept) -> DRAIN (last pair issued) -> DONE (last psum added) -> IDLE.
//   DONE -> IDLE occurs on o_ResValid & i_ResReady; o_JobReady rises the following cycle.
// - ISSUE: one pair per cycle, o_Issue=1, no bubbles.
//   Loop order: tile outer, then weight slice, then activation slice innermost, all ascending from 0.
//   Total issue cycles = (NumTiles+1)*(PrecW+1)*(PrecA+1).
// - Signs are combinational on the issued indices:
//   o_SignI = (o_ASlice==PrecA), o_SignW = (o_WSlice==PrecW).
//   A 1-slice operand therefore has its sole slice marked signed.
// - Shift tag sh = SLICE_W*(ASlice+WSlice) travels with the issue through a PSUM_LAT-deep valid/tag delay line.
// - When the delayed valid is set: acc <= acc + (sign_extend(i_Psum) <<< sh). Two's-complement wrap at ACC_W, no saturation.
// - DRAIN: no issues; waits until the delay line is empty (PSUM_LAT cycles after last issue).
//   Moves to DONE the cycle after the last add.
// - DONE: o_ResValid=1 and o_Result=acc, held stable until accepted.
//   i_JobValid in any non-IDLE state is ignored, not queued.
// - o_Result retains the last value after acceptance until the next job's DONE.
// TESTING
// - Min job: PrecA=0,PrecW=0,NumTiles=0, i_Psum=-5 -> 1 issue with SignI=SignW=1; Result=-5; ResValid 2 cycles after issue (LAT=1).
// - 2x2 slices, 1 tile, psum=1 per pair -> issue order (a,w)=(0,0),(1,0),(0,1),(1,1); Result=1+4+4+16=25; SignI high on a=1 only.
// - PrecA=3,PrecW=3,NumTiles=2 -> exactly 48 consecutive issue cycles, TileIdx 0..2; Result equals the model sum of shifted psums.
// - Backpressure: hold i_ResReady=0 for 5 cycles in DONE -> Result stable, JobReady=0, new i_JobValid ignored; release -> IDLE, JobReady=1 next cycle.
// - Reset asserted mid-ISSUE (pair 3 of 16) -> next cycle IDLE, Issue=0, ResValid=0; next job's Result excludes the stale psums.
// - Wrap: ACC_W=12, psum=1023 on a (3,3) shift-12 pair -> Result wraps per two's complement, no saturation.

Source files
------------

// File: rtl/sip_dot_slice_sched.sv
// Job sequencer for the bit-sliced sip_dot datapath: walks (tile, weight slice, activation slice)
// pairs, tags each issue with its shift amount and shift-accumulates the returned adder sums.
module sip_dot_slice_sched #(
  parameter int SLICE_W  = 2,
  parameter int MAX_SLC  = 4,
  parameter int PSUM_W   = 11,
  parameter int ACC_W    = 32,
  parameter int TILE_W   = 8,
  parameter int PSUM_LAT = 1
) (
  input  logic                        i_CLK,
  input  logic                        i_RST,
  input  logic                        i_JobValid,
  output logic                        o_JobReady,
  input  logic [$clog2(MAX_SLC)-1:0]  i_PrecA,
  input  logic [$clog2(MAX_SLC)-1:0]  i_PrecW,
  input  logic [TILE_W-1:0]           i_NumTiles,
  output logic                        o_Issue,
  output logic [TILE_W-1:0]           o_TileIdx,
  output logic [$clog2(MAX_SLC)-1:0]  o_ASlice,
  output logic [$clog2(MAX_SLC)-1:0]  o_WSlice,
  output logic                        o_SignI,
  output logic                        o_SignW,
  input  logic [PSUM_W-1:0]           i_Psum,
  output logic                        o_ResValid,
  input  logic                        i_ResReady,
  output logic [ACC_W-1:0]            o_Result,
  output logic                        o_Busy
);

  localparam int SLC_W = $clog2(MAX_SLC);
  localparam int SH_W  = $clog2(2 * SLICE_W * (MAX_SLC - 1) + 1);
  localparam logic [PSUM_LAT-1:0] LAST_MASK = PSUM_LAT'(1) << (PSUM_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  state_t              state_q;
  logic [SLC_W-1:0]    prec_a_q, prec_w_q, a_q, w_q;
  logic [TILE_W-1:0]   ntile_q, tile_q;
  logic [ACC_W-1:0]    acc_q, acc_d, result_q;
  logic                res_valid_q;
  logic [PSUM_LAT-1:0] dl_valid_q;
  logic [SH_W-1:0]     dl_sh_q [PSUM_LAT];

  logic                issue_s, a_last_s, w_last_s, t_last_s, add_s, drain_done_s;
  logic [SH_W-1:0]     sh_s;
  logic [ACC_W-1:0]    psum_ext_s;

  always_comb begin
    issue_s      = (state_q == ST_ISSUE);
    a_last_s     = (a_q == prec_a_q);
    w_last_s     = (w_q == prec_w_q);
    t_last_s     = (tile_q == ntile_q);
    sh_s         = SH_W'(SLICE_W) * (SH_W'(a_q) + SH_W'(w_q));
    psum_ext_s   = ACC_W'($signed(i_Psum));
    add_s        = dl_valid_q[PSUM_LAT-1];
    // Last add in flight and nothing queued behind it.
    drain_done_s = add_s && ((dl_valid_q & ~LAST_MASK) == '0);
    if (add_s) begin
      acc_d = acc_q + (psum_ext_s << dl_sh_q[PSUM_LAT-1]);
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= ST_IDLE;
      prec_a_q    <= '0;
      prec_w_q    <= '0;
      ntile_q     <= '0;
      a_q         <= '0;
      w_q         <= '0;
      tile_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      dl_valid_q  <= '0;
      for (int i = 0; i < PSUM_LAT; i++) dl_sh_q[i] <= '0;
    end else begin
      dl_valid_q[0] <= issue_s;
      dl_sh_q[0]    <= sh_s;
      for (int i = PSUM_LAT - 1; i > 0; i--) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_sh_q[i]    <= dl_sh_q[i-1];
      end
      acc_q <= acc_d;
      case (state_q)
        ST_IDLE: begin
          if (i_JobValid) begin
            prec_a_q <= i_PrecA;
            prec_w_q <= i_PrecW;
            ntile_q  <= i_NumTiles;
            a_q      <= '0;
            w_q      <= '0;
            tile_q   <= '0;
            acc_q    <= '0;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Activation slice innermost, then weight slice, then tile.
          if (!a_last_s) begin
            a_q <= a_q + SLC_W'(1);
          end else begin
            a_q <= '0;
            if (!w_last_s) begin
              w_q <= w_q + SLC_W'(1);
            end else begin
              w_q <= '0;
              if (!t_last_s) begin
                tile_q <= tile_q + TILE_W'(1);
              end else begin
                tile_q  <= '0;
                state_q <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            result_q    <= acc_d;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ResReady) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_JobReady = (state_q == ST_IDLE);
  assign o_Busy     = (state_q != ST_IDLE);
  assign o_Issue    = issue_s;
  assign o_TileIdx  = tile_q;
  assign o_ASlice   = a_q;
  assign o_WSlice   = w_q;
  assign o_SignI    = issue_s && a_last_s;
  assign o_SignW    = issue_s && w_last_s;
  assign o_ResValid = res_valid_q;
  assign o_Result   = result_q;

endmodule

// File: tb/tb_sip_dot_slice_sched.sv
// Directed bench for sip_dot_slice_sched: issue-order and result scoreboards fed from a
// bench-side model; a 12-bit-accumulator copy runs alongside to check wrap-around.
module tb_sip_dot_slice_sched;

  logic        clk;
  logic        i_RST, i_JobValid, i_ResReady;
  logic [1:0]  i_PrecA, i_PrecW;
  logic [7:0]  i_NumTiles;
  logic [10:0] i_Psum;
  logic        o_JobReady, o_Issue, o_SignI, o_SignW, o_ResValid, o_Busy;
  logic [7:0]  o_TileIdx;
  logic [1:0]  o_ASlice, o_WSlice;
  logic [31:0] o_Result;
  logic        w_JobReady, w_Issue, w_SignI, w_SignW, w_ResValid, w_Busy;
  logic [7:0]  w_TileIdx;
  logic [1:0]  w_ASlice, w_WSlice;
  logic [11:0] w_Result;

  int errors = 0;
  int checks = 0;
  int cur_mode = 0;
  int cur_cv = 0;
  logic [10:0] next_psum = '0;
  logic [13:0] exp_iss [$];
  logic [63:0] exp_res [$];

  sip_dot_slice_sched u_dut (
    .i_CLK(clk), .i_RST(i_RST), .i_JobValid(i_JobValid), .o_JobReady(o_JobReady),
    .i_PrecA(i_PrecA), .i_PrecW(i_PrecW), .i_NumTiles(i_NumTiles), .o_Issue(o_Issue),
    .o_TileIdx(o_TileIdx), .o_ASlice(o_ASlice), .o_WSlice(o_WSlice), .o_SignI(o_SignI),
    .o_SignW(o_SignW), .i_Psum(i_Psum), .o_ResValid(o_ResValid), .i_ResReady(i_ResReady),
    .o_Result(o_Result), .o_Busy(o_Busy)
  );

  sip_dot_slice_sched #(.ACC_W(12)) u_wrap (
    .i_CLK(clk), .i_RST(i_RST), .i_JobValid(i_JobValid), .o_JobReady(w_JobReady),
    .i_PrecA(i_PrecA), .i_PrecW(i_PrecW), .i_NumTiles(i_NumTiles), .o_Issue(w_Issue),
    .o_TileIdx(w_TileIdx), .o_ASlice(w_ASlice), .o_WSlice(w_WSlice), .o_SignI(w_SignI),
    .o_SignW(w_SignW), .i_Psum(i_Psum), .o_ResValid(w_ResValid), .i_ResReady(i_ResReady),
    .o_Result(w_Result), .o_Busy(w_Busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int psum_of(int mode, int cv, int t, int a, int w);
    if (mode == 0) return cv;
    return ((t * 37 + a * 11 + w * 5 + 3) % 2048) - 1024;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int pa, input int pw, input int nt, input int mode, input int cv);
    longint sum = 0;
    cur_mode = mode;
    cur_cv   = cv;
    for (int t = 0; t <= nt; t++)
      for (int w = 0; w <= pw; w++)
        for (int a = 0; a <= pa; a++) begin
          exp_iss.push_back({8'(t), 2'(a), 2'(w), (a == pa), (w == pw)});
          sum += longint'(psum_of(mode, cv, t, a, w)) <<< (2 * (a + w));
        end
    exp_res.push_back(64'(sum));
    i_PrecA    = 2'(pa);
    i_PrecW    = 2'(pw);
    i_NumTiles = 8'(nt);
    i_JobValid = 1'b1;
    step();
    i_JobValid = 1'b0;
    chk("job_accepted_busy", 64'(o_Busy), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!o_JobReady && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(o_JobReady), 64'd1);
  endtask

  // Scoreboard monitor: checks each issue, answers it with a psum one cycle later, checks results.
  initial begin
    logic [13:0] e;
    logic [63:0] r;
    forever begin
      @(negedge clk);
      i_Psum = next_psum;
      if (o_Issue) begin
        chk("issue_expected", 64'(exp_iss.size() != 0), 64'd1);
        if (exp_iss.size() != 0) begin
          e = exp_iss.pop_front();
          chk("issue_pair", 64'({o_TileIdx, o_ASlice, o_WSlice, o_SignI, o_SignW}), 64'(e));
        end
        next_psum = 11'(psum_of(cur_mode, cur_cv, int'(o_TileIdx), int'(o_ASlice), int'(o_WSlice)));
      end else begin
        next_psum = 11'($urandom);
      end
      if (o_ResValid && i_ResReady) begin
        chk("result_expected", 64'(exp_res.size() != 0), 64'd1);
        if (exp_res.size() != 0) begin
          r = exp_res.pop_front();
          chk("result", 64'(o_Result), 64'(r[31:0]));
          chk("result_wrap12", 64'(w_Result), 64'(r[11:0]));
        end
      end
    end
  end

  initial begin
    int cnt;
    i_RST = 1'b1; i_JobValid = 1'b0; i_ResReady = 1'b1;
    i_PrecA = '0; i_PrecW = '0; i_NumTiles = '0; i_Psum = '0;
    repeat (3) step();
    i_RST = 1'b0;
    chk("rst_jobready", 64'(o_JobReady), 64'd1);
    chk("rst_issue", 64'(o_Issue), 64'd0);
    chk("rst_resvalid", 64'(o_ResValid), 64'd0);
    chk("rst_busy", 64'(o_Busy), 64'd0);
    chk("rst_result", 64'(o_Result), 64'd0);
    chk("rst_idx_signs", 64'({o_TileIdx, o_ASlice, o_WSlice, o_SignI, o_SignW}), 64'd0);

    // Minimal job: single pair, latency check.
    start_job(0, 0, 0, 0, -5);
    chk("min_issue", 64'({o_Issue, o_SignI, o_SignW}), 64'b111);
    step();
    chk("min_resvalid_c1", 64'({o_Issue, o_ResValid}), 64'b00);
    step();
    chk("min_resvalid_c2", 64'(o_ResValid), 64'd1);
    chk("min_result", 64'(o_Result), 64'hFFFF_FFFB);
    step();
    chk("min_jobready_after", 64'({o_JobReady, o_ResValid}), 64'b10);

    // 2x2 slices, one tile, psum=1.
    start_job(1, 1, 0, 0, 1);
    wait_idle(50);
    chk("2x2_result_held", 64'(o_Result), 64'd25);

    // 4x4 slices across 3 tiles: no bubbles.
    start_job(3, 3, 2, 1, 0);
    cnt = 0;
    while (o_Issue && cnt < 100) begin
      cnt++;
      step();
    end
    chk("issue_count_48", 64'(cnt), 64'd48);
    wait_idle(50);

    // Backpressure in DONE with an ignored job request.
    i_ResReady = 1'b0;
    start_job(1, 0, 1, 1, 0);
    cnt = 0;
    while (!o_ResValid && cnt < 50) begin
      cnt++;
      step();
    end
    chk("bp_resvalid", 64'(o_ResValid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      i_JobValid = 1'b1;
      step();
      chk("bp_result_stable", 64'(o_Result), 64'(exp_res[0][31:0]));
      chk("bp_jobready_low", 64'({o_JobReady, o_ResValid}), 64'b01);
    end
    i_JobValid = 1'b0;
    i_ResReady = 1'b1;
    step();
    chk("bp_release_idle", 64'({o_JobReady, o_Busy, o_ResValid}), 64'b100);
    step();
    chk("bp_no_new_issue", 64'({o_Issue, o_Busy}), 64'b00);
    chk("bp_iss_queue_empty", 64'(exp_iss.size()), 64'd0);

    // Reset during pair 3 of 16.
    start_job(1, 1, 3, 1, 0);
    step();
    step();
    chk("mid_pair3", 64'({o_TileIdx, o_ASlice, o_WSlice}), 64'({8'd0, 2'd0, 2'd1}));
    i_RST = 1'b1;
    step();
    chk("mid_rst_state", 64'({o_Issue, o_ResValid, o_JobReady, o_Busy}), 64'b0010);
    chk("mid_rst_result", 64'(o_Result), 64'd0);
    exp_iss.delete();
    exp_res.delete();
    i_RST = 1'b0;
    step();
    start_job(1, 1, 0, 0, 3);
    wait_idle(50);
    chk("post_rst_result", 64'(o_Result), 64'd75);

    // Wrap: all-max psums on 4x4 slices; the 12-bit copy is checked against the model modulo 2^12.
    start_job(3, 3, 0, 0, 1023);
    wait_idle(50);
    start_job(2, 1, 1, 0, -1024);
    wait_idle(50);

    step();
    chk("final_iss_queue_empty", 64'(exp_iss.size()), 64'd0);
    chk("final_res_queue_empty", 64'(exp_res.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
